prog_encoder: RTL and testbench

Sequential program loader that encodes field-level instruction requests (opcode, DA, AA, BA, immediate) into 32-bit RISC instruction words and writes them into instruction memory. It is the encode side of the instruction format the CPU decoder consumes, and sits between the host/test-harness program source and the instruction-memory write port. It packs fields, checks opcodes, and tracks addresses, completion and errors.

---
 rtl/prog_encoder_pkg.sv | 63 ++++++
 rtl/prog_encoder_instr_pack.sv | 46 ++++
 rtl/prog_encoder.sv | 116 +++++++++++
 tb/tb_prog_encoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_encoder_pkg.sv
// Shared opcode table, immediate-class list, error codes and FSM state type
// for the instruction-word encoder and its packer.
package prog_encoder_pkg;

  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_INC  = 7'h01;
  localparam logic [6:0] OP_ADD  = 7'h02;
  localparam logic [6:0] OP_NEG  = 7'h03;
  localparam logic [6:0] OP_SUB  = 7'h05;
  localparam logic [6:0] OP_DEC  = 7'h06;
  localparam logic [6:0] OP_CMP  = 7'h07;
  localparam logic [6:0] OP_AND  = 7'h08;
  localparam logic [6:0] OP_OR   = 7'h09;
  localparam logic [6:0] OP_XOR  = 7'h0A;
  localparam logic [6:0] OP_NOT  = 7'h0B;
  localparam logic [6:0] OP_MOVB = 7'h0C;
  localparam logic [6:0] OP_LSR  = 7'h0D;
  localparam logic [6:0] OP_LSL  = 7'h0E;
  localparam logic [6:0] OP_LD   = 7'h10;
  localparam logic [6:0] OP_ST   = 7'h20;
  localparam logic [6:0] OP_ADI  = 7'h22;
  localparam logic [6:0] OP_SBI  = 7'h25;
  localparam logic [6:0] OP_ANI  = 7'h28;
  localparam logic [6:0] OP_ORI  = 7'h29;
  localparam logic [6:0] OP_XRI  = 7'h2A;
  localparam logic [6:0] OP_JML  = 7'h30;
  localparam logic [6:0] OP_MOVA = 7'h40;
  localparam logic [6:0] OP_AIU  = 7'h42;
  localparam logic [6:0] OP_SIU  = 7'h45;
  localparam logic [6:0] OP_BNZ  = 7'h48;
  localparam logic [6:0] OP_BZ   = 7'h60;
  localparam logic [6:0] OP_SLT  = 7'h65;
  localparam logic [6:0] OP_JMP  = 7'h68;
  localparam logic [6:0] OP_JMR  = 7'h70;

  localparam int NUM_OPS     = 30;
  localparam int NUM_IMM_OPS = 11;

  // Flattened 7-bit entries; entry gi lives at [gi*7 +: 7].
  localparam logic [NUM_OPS*7-1:0] LEGAL_OPS = {
    OP_NOP, OP_INC, OP_ADD, OP_NEG, OP_SUB, OP_DEC, OP_CMP, OP_AND,
    OP_OR,  OP_XOR, OP_NOT, OP_MOVB, OP_LSR, OP_LSL, OP_LD, OP_ST,
    OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_JML, OP_MOVA, OP_AIU,
    OP_SIU, OP_BNZ, OP_BZ, OP_SLT, OP_JMP, OP_JMR
  };

  localparam logic [NUM_IMM_OPS*7-1:0] IMM_OPS = {
    OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_AIU,
    OP_SIU, OP_BZ,  OP_BNZ, OP_JMP, OP_JML
  };

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OPC  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/prog_encoder_instr_pack.sv
// Combinational instruction packer: builds the 32-bit word and flags whether the
// opcode is legal (only when PROG_ENC_OPCHECK_EN is defined; otherwise always legal).
module instr_pack
  import prog_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  da,
  input  logic [4:0]  aa,
  input  logic [4:0]  ba,
  input  logic [14:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic [NUM_IMM_OPS-1:0] imm_hit;
  logic                   is_imm;
  logic [14:0]            low15;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IMM_OPS; gi++) begin : g_imm
      assign imm_hit[gi] = (opcode == IMM_OPS[gi*7 +: 7]);
    end
  endgenerate

  assign is_imm = |imm_hit;

`ifdef PROG_ENC_OPCHECK_EN
  logic [NUM_OPS-1:0] op_hit;

  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_legal
      assign op_hit[gi] = (opcode == LEGAL_OPS[gi*7 +: 7]);
    end
  endgenerate

  assign legal = |op_hit;
`else
  assign legal = 1'b1;
`endif

  // Register-class words carry BA in [14:10] with the rest of the low field zero.
  assign low15 = is_imm ? imm : {ba, 10'b0};
  assign word  = {opcode, da, aa, low15};

endmodule

// File: rtl/prog_encoder.sv
// Program loader: accepts field-level instruction requests, packs them and writes
// them sequentially into instruction memory. Opcode checking gated by PROG_ENC_OPCHECK_EN.
module prog_encoder
  import prog_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_da,
  input  logic [4:0]        in_aa,
  input  logic [4:0]        in_ba,
  input  logic [14:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic              legal;
  logic              xfer;

  instr_pack u_pack (
    .opcode (in_opcode),
    .da     (in_da),
    .aa     (in_aa),
    .ba     (in_ba),
    .imm    (in_imm),
    .word   (word),
    .legal  (legal)
  );

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_NONE;
      count     <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_RUN;
            addr     <= base_addr;
            count    <= '0;
            err      <= ERR_NONE;
            done     <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (!legal) begin
              err      <= ERR_OPC;
              state    <= S_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= word;
              count     <= count + CNT_ONE;
              if (in_last) begin
                done     <= 1'b1;
                state    <= S_DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
              end else if (addr == ADDR_MAX) begin
                // Top of memory reached with more to come: stop rather than wrap.
                err      <= ERR_OVF;
                state    <= S_ERR;
                in_ready <= 1'b0;
                busy     <= 1'b0;
              end else begin
                addr <= addr + ADDR_ONE;
              end
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder: a spec-level model checked every cycle plus
// hand-computed literal expectations for the encoded words and key states.
module tb_prog_encoder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_da = '0, in_aa = '0, in_ba = '0;
  logic [14:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done;
  logic [1:0]    err;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  prog_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_da(in_da), .in_aa(in_aa), .in_ba(in_ba), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  // Opcode tables written out independently of the design package.
  bit legal_tab [128];
  bit imm_tab   [128];
  initial begin
    int legal_list [30] = '{'h00, 'h01, 'h02, 'h03, 'h05, 'h06, 'h07, 'h08,
                            'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h10, 'h20,
                            'h22, 'h25, 'h28, 'h29, 'h2A, 'h30, 'h40, 'h42,
                            'h45, 'h48, 'h60, 'h65, 'h68, 'h70};
    int imm_list [11] = '{'h22, 'h25, 'h28, 'h29, 'h2A, 'h42, 'h45, 'h60,
                          'h48, 'h68, 'h30};
    for (int i = 0; i < 128; i++) begin
      legal_tab[i] = 1'b0;
      imm_tab[i]   = 1'b0;
    end
    foreach (legal_list[i]) legal_tab[legal_list[i]] = 1'b1;
    foreach (imm_list[i]) imm_tab[imm_list[i]] = 1'b1;
  end

  function automatic logic [31:0] encode(input logic [6:0] op, input logic [4:0] d,
                                         input logic [4:0] a, input logic [4:0] b,
                                         input logic [14:0] im);
    int w;
    w = (int'(op) << 25) + (int'(d) << 20) + (int'(a) << 15);
    if (imm_tab[op]) w = w + int'(im);
    else             w = w + (int'(b) << 10);
    return 32'(w);
  endfunction

  function automatic bit op_ok(input logic [6:0] op);
`ifdef PROG_ENC_OPCHECK_EN
    return legal_tab[op];
`else
    return 1'b1;
`endif
  endfunction

  // Spec-level model: a loading flag, the next address and the expected outputs.
  bit          m_run;
  int          m_addr;
  bit          e_we, e_done;
  int          e_maddr, e_err, e_count;
  logic [31:0] e_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_addr = 0; e_we = 0; e_maddr = 0; e_wdata = 0;
      e_done = 0; e_err = 0; e_count = 0;
    end else begin
      e_we = 0;
      if (m_run) begin
        if (in_valid) begin
          if (!op_ok(in_opcode)) begin
            e_err = 1; m_run = 0;
          end else begin
            e_we = 1; e_maddr = m_addr; e_count = e_count + 1;
            e_wdata = encode(in_opcode, in_da, in_aa, in_ba, in_imm);
            if (in_last) begin
              e_done = 1; m_run = 0;
            end else if (m_addr == (1 << AW) - 1) begin
              e_err = 2; m_run = 0;
            end else begin
              m_addr = m_addr + 1;
            end
          end
        end
      end else if (start) begin
        m_run = 1; m_addr = int'(base_addr); e_count = 0; e_err = 0; e_done = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model in_ready", 32'(in_ready), 32'(m_run));
    chk("model busy", 32'(busy), 32'(m_run));
    chk("model mem_we", 32'(mem_we), 32'(e_we));
    chk("model mem_addr", 32'(mem_addr), 32'(e_maddr));
    chk("model mem_wdata", mem_wdata, e_wdata);
    chk("model done", 32'(done), 32'(e_done));
    chk("model err", 32'(err), 32'(e_err));
    chk("model count", 32'(count), 32'(e_count));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    start = 1'b1; base_addr = b;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] b, input logic [14:0] im, input logic l);
    in_valid = 1'b1; in_opcode = op; in_da = d; in_aa = a; in_ba = b;
    in_imm = im; in_last = l;
    cyc();
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Single ADD with last.
    do_start(8'h10);
    chk("run ready", 32'(in_ready), 32'd1);
    send(7'h02, 5'd3, 5'd1, 5'd2, 15'h0, 1'b1);
    idle_in();
    chk("add we", 32'(mem_we), 32'd1);
    chk("add addr", 32'(mem_addr), 32'h10);
    chk("add word", mem_wdata, 32'h0430_8800);
    chk("add done", 32'(done), 32'd1);
    chk("add count", 32'(count), 32'd1);
    chk("add ready drop", 32'(in_ready), 32'd0);
    cyc();
    chk("add we pulse", 32'(mem_we), 32'd0);

    // Four back-to-back writes.
    do_start(8'h20);
    send(7'h22, 5'd1, 5'd2, 5'd0, 15'h7FFF, 1'b0);
    chk("b2b adi word", mem_wdata, 32'h4411_7FFF);
    chk("b2b adi addr", 32'(mem_addr), 32'h20);
    send(7'h05, 5'd4, 5'd5, 5'd6, 15'h1234, 1'b0);
    chk("b2b sub word", mem_wdata, 32'h0A42_9800);
    send(7'h10, 5'd7, 5'd8, 5'd0, 15'h0, 1'b0);
    chk("b2b ld we", 32'(mem_we), 32'd1);
    send(7'h68, 5'd0, 5'd5, 5'd0, 15'h0004, 1'b1);
    idle_in();
    chk("b2b jmp word", mem_wdata, 32'hD002_8004);
    chk("b2b jmp addr", 32'(mem_addr), 32'h23);
    chk("b2b count", 32'(count), 32'd4);
    cyc();

    // Illegal opcode mid-stream.
    do_start(8'h40);
    send(7'h05, 5'd1, 5'd1, 5'd1, 15'h0, 1'b0);
    send(7'h7F, 5'd1, 5'd1, 5'd1, 15'h0, 1'b0);
`ifdef PROG_ENC_OPCHECK_EN
    chk("illegal no write", 32'(mem_we), 32'd0);
    chk("illegal err", 32'(err), 32'd1);
    chk("illegal ready", 32'(in_ready), 32'd0);
    send(7'h02, 5'd1, 5'd1, 5'd1, 15'h0, 1'b1);
    idle_in();
    chk("illegal after", 32'(mem_we), 32'd0);
`else
    chk("unchecked write", 32'(mem_we), 32'd1);
    chk("unchecked word", mem_wdata, 32'hFE10_8400);
    chk("unchecked err", 32'(err), 32'd0);
    send(7'h02, 5'd1, 5'd1, 5'd1, 15'h0, 1'b1);
    idle_in();
    chk("unchecked done", 32'(done), 32'd1);
    chk("unchecked count", 32'(count), 32'd3);
`endif
    cyc();

    // Address overflow at the top of memory.
    do_start(8'hFE);
    send(7'h02, 5'd1, 5'd2, 5'd3, 15'h0, 1'b0);
    chk("ovf first addr", 32'(mem_addr), 32'hFE);
    send(7'h02, 5'd1, 5'd2, 5'd3, 15'h0, 1'b0);
    chk("ovf second addr", 32'(mem_addr), 32'hFF);
    chk("ovf err", 32'(err), 32'd2);
    chk("ovf ready", 32'(in_ready), 32'd0);
    send(7'h02, 5'd1, 5'd2, 5'd3, 15'h0, 1'b0);
    idle_in();
    chk("ovf third dropped", 32'(mem_we), 32'd0);
    chk("ovf count", 32'(count), 32'd2);
    cyc();

    // Reset with a write pending.
    do_start(8'h50);
    send(7'h09, 5'd2, 5'd2, 5'd2, 15'h0, 1'b0);
    idle_in();
    chk("pre-reset we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst we", 32'(mem_we), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst idle ready", 32'(in_ready), 32'd0);

    // Start pulsed during RUN is ignored.
    do_start(8'h60);
    send(7'h02, 5'd1, 5'd1, 5'd1, 15'h0, 1'b0);
    start = 1'b1; base_addr = 8'h80;
    send(7'h05, 5'd1, 5'd1, 5'd1, 15'h0, 1'b0);
    start = 1'b0;
    chk("restart ignored addr", 32'(mem_addr), 32'h61);
    send(7'h08, 5'd1, 5'd1, 5'd1, 15'h0, 1'b1);
    idle_in();
    chk("restart final addr", 32'(mem_addr), 32'h62);
    chk("restart count", 32'(count), 32'd3);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
